// File: rtl/time_pkg.sv
// Shared time-field layout, ranges and editor FSM encodings.
// Imported by the time counter and by the time-set editor.
package time_pkg;

    localparam int TIME_W   = 17;
    localparam int MER_BIT  = 16;
    localparam int HOUR_MSB = 15;
    localparam int HOUR_LSB = 12;
    localparam int MIN_MSB  = 11;
    localparam int MIN_LSB  = 6;
    localparam int SEC_MSB  = 5;
    localparam int SEC_LSB  = 0;

    localparam logic [3:0] HOUR_MAX = 4'd11;
    localparam logic [5:0] MS_MAX   = 6'd59;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        EDIT_HOUR = 3'd1,
        EDIT_MIN  = 3'd2,
        EDIT_SEC  = 3'd3,
        EDIT_MER  = 3'd4,
        COMMIT    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        FIELD_HOUR = 2'd0,
        FIELD_MIN  = 2'd1,
        FIELD_SEC  = 2'd2,
        FIELD_MER  = 2'd3
    } field_t;

    function automatic logic is_edit(input state_t s);
        return (s == EDIT_HOUR) || (s == EDIT_MIN) || (s == EDIT_SEC) || (s == EDIT_MER);
    endfunction

    // Fold a 24h-style hour into 12h+PM and zero any out-of-range minute/second.
    function automatic logic [TIME_W-1:0] sanitize_time(input logic [TIME_W-1:0] t);
        logic [3:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic       mer;
        h   = t[HOUR_MSB:HOUR_LSB];
        m   = t[MIN_MSB:MIN_LSB];
        s   = t[SEC_MSB:SEC_LSB];
        mer = t[MER_BIT];
        if (h > HOUR_MAX) begin
            h   = h - 4'd12;
            mer = 1'b1;
        end
        if (m > MS_MAX) m = '0;
        if (s > MS_MAX) s = '0;
        return {mer, h, m, s};
    endfunction

endpackage

// File: rtl/time_set_editor_tick_counter.sv
// Free-running modulo-N counter with synchronous clear; tick marks the
// cycle in which the counter sits at N-1 and is about to wrap.
module tick_counter #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int           W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/time_set_editor.sv
// Button-driven time editor: snapshots CUR_TIME, edits fields with up/down,
// and emits the shadow value with a one-cycle IS_SAVED_TIME load strobe.
module time_set_editor
    import time_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000,
    parameter int BLINK_HALF  = 50
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic [TIME_W-1:0] CUR_TIME,
    input  logic              BTN_MODE,
    input  logic              BTN_NEXT,
    input  logic              BTN_UP,
    input  logic              BTN_DOWN,
    input  logic              BTN_SAVE,
    input  logic              BTN_CANCEL,
    output logic [TIME_W-1:0] IN_TIME,
    output logic              IS_SAVED_TIME,
    output logic              EDITING,
    output logic [1:0]        FIELD_SEL,
    output logic              BLINK,
    output state_t            FSM_STATE
);

    state_t            state;
    state_t            state_d;
    logic [TIME_W-1:0] shadow_d;
    logic              saved_d;
    logic              editing_d;
    logic [1:0]        field_d;
    logic              blink_d;

    logic in_edit;
    logic btn_any;
    logic step_en;
    logic cnt_clear;
    logic tmo_tick;
    logic blink_tick;

    logic [3:0] hour;
    logic [5:0] mins;
    logic [5:0] secs;

    assign in_edit = is_edit(state);
    assign btn_any = BTN_MODE | BTN_NEXT | BTN_UP | BTN_DOWN | BTN_SAVE | BTN_CANCEL;
    assign step_en = in_edit & ~BTN_CANCEL & ~BTN_SAVE & ~BTN_NEXT & (BTN_UP ^ BTN_DOWN);

    assign hour = IN_TIME[HOUR_MSB:HOUR_LSB];
    assign mins = IN_TIME[MIN_MSB:MIN_LSB];
    assign secs = IN_TIME[SEC_MSB:SEC_LSB];

    // Both counters restart on any press and stay parked outside the edit states.
    assign cnt_clear = btn_any | ~in_edit;

    tick_counter #(.N(TIMEOUT_CYC)) u_timeout (
        .clk    (CLK),
        .resetn (RESETN),
        .clear  (cnt_clear),
        .enable (in_edit),
        .tick   (tmo_tick)
    );

    tick_counter #(.N(BLINK_HALF)) u_blink (
        .clk    (CLK),
        .resetn (RESETN),
        .clear  (cnt_clear),
        .enable (in_edit),
        .tick   (blink_tick)
    );

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state         <= IDLE;
            IN_TIME       <= '0;
            IS_SAVED_TIME <= 1'b0;
            EDITING       <= 1'b0;
            FIELD_SEL     <= FIELD_HOUR;
            BLINK         <= 1'b0;
        end else begin
            state         <= state_d;
            IN_TIME       <= shadow_d;
            IS_SAVED_TIME <= saved_d;
            EDITING       <= editing_d;
            FIELD_SEL     <= field_d;
            BLINK         <= blink_d;
        end
    end

    // Button priority inside EDIT_*: CANCEL > SAVE > NEXT > step; timeout only on quiet cycles.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (BTN_MODE) state_d = EDIT_HOUR;
            end
            EDIT_HOUR, EDIT_MIN, EDIT_SEC, EDIT_MER: begin
                if (BTN_CANCEL) begin
                    state_d = IDLE;
                end else if (BTN_SAVE) begin
                    state_d = COMMIT;
                end else if (BTN_NEXT) begin
                    case (state)
                        EDIT_HOUR: state_d = EDIT_MIN;
                        EDIT_MIN:  state_d = EDIT_SEC;
                        EDIT_SEC:  state_d = EDIT_MER;
                        default:   state_d = EDIT_HOUR;
                    endcase
                end else if (tmo_tick) begin
                    state_d = IDLE;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shadow_d = IN_TIME;
        if ((state == IDLE) && BTN_MODE) begin
            shadow_d = sanitize_time(CUR_TIME);
        end else if (step_en) begin
            case (state)
                EDIT_HOUR: begin
                    if (BTN_UP) shadow_d[HOUR_MSB:HOUR_LSB] = (hour == HOUR_MAX) ? 4'd0 : hour + 4'd1;
                    else        shadow_d[HOUR_MSB:HOUR_LSB] = (hour == 4'd0) ? HOUR_MAX : hour - 4'd1;
                end
                EDIT_MIN: begin
                    if (BTN_UP) shadow_d[MIN_MSB:MIN_LSB] = (mins == MS_MAX) ? 6'd0 : mins + 6'd1;
                    else        shadow_d[MIN_MSB:MIN_LSB] = (mins == 6'd0) ? MS_MAX : mins - 6'd1;
                end
                EDIT_SEC: begin
                    if (BTN_UP) shadow_d[SEC_MSB:SEC_LSB] = (secs == MS_MAX) ? 6'd0 : secs + 6'd1;
                    else        shadow_d[SEC_MSB:SEC_LSB] = (secs == 6'd0) ? MS_MAX : secs - 6'd1;
                end
                EDIT_MER: shadow_d[MER_BIT] = ~IN_TIME[MER_BIT];
                default:  shadow_d = IN_TIME;
            endcase
        end

        saved_d   = (state_d == COMMIT);
        editing_d = is_edit(state_d);

        case (state_d)
            EDIT_MIN: field_d = FIELD_MIN;
            EDIT_SEC: field_d = FIELD_SEC;
            EDIT_MER: field_d = FIELD_MER;
            default:  field_d = FIELD_HOUR;
        endcase

        // A press forces the field visible so the new value shows at once.
        if (!is_edit(state_d))  blink_d = 1'b0;
        else if (btn_any)       blink_d = 1'b1;
        else if (blink_tick)    blink_d = ~BLINK;
        else                    blink_d = BLINK;
    end

    assign FSM_STATE = state;

endmodule

// File: tb/tb_time_set_editor.sv
// Bench for time_set_editor: a field-level reference model predicts every
// cycle's outputs and each saved time; a negedge monitor checks them.
module tb_time_set_editor;
  import time_pkg::*;

  localparam int TMO = 20;
  localparam int BH  = 5;

  localparam logic [5:0] K_MODE   = 6'b000001;
  localparam logic [5:0] K_NEXT   = 6'b000010;
  localparam logic [5:0] K_UP     = 6'b000100;
  localparam logic [5:0] K_DOWN   = 6'b001000;
  localparam logic [5:0] K_SAVE   = 6'b010000;
  localparam logic [5:0] K_CANCEL = 6'b100000;

  // Handshake: IS_SAVED_TIME is a one-cycle valid with no ready; IN_TIME is
  // the payload, compared against the head of exp_q in the strobe cycle.

  logic        clk;
  logic        resetn;
  logic [16:0] cur_time;
  logic [5:0]  btn;
  logic [16:0] in_time;
  logic        is_saved_time;
  logic        editing;
  logic [1:0]  field_sel;
  logic        blink;
  state_t      fsm_state;

  typedef struct {
    logic [16:0] t;
    logic        sv;
    logic        ed;
    logic        bl;
    logic [1:0]  fs;
    logic [2:0]  st;
  } snap_t;

  logic [16:0] exp_q[$];
  snap_t       stat_q[$];

  int checks = 0;
  int errors = 0;

  // model state: md 0 idle, 1 editing, 2 commit
  int m_md = 0, m_f = 0, m_h = 0, m_mi = 0, m_s = 0, m_mer = 0, m_since = 0;

  time_set_editor #(.TIMEOUT_CYC(TMO), .BLINK_HALF(BH)) dut (
    .CLK           (clk),
    .RESETN        (resetn),
    .CUR_TIME      (cur_time),
    .BTN_MODE      (btn[0]),
    .BTN_NEXT      (btn[1]),
    .BTN_UP        (btn[2]),
    .BTN_DOWN      (btn[3]),
    .BTN_SAVE      (btn[4]),
    .BTN_CANCEL    (btn[5]),
    .IN_TIME       (in_time),
    .IS_SAVED_TIME (is_saved_time),
    .EDITING       (editing),
    .FIELD_SEL     (field_sel),
    .BLINK         (blink),
    .FSM_STATE     (fsm_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    resetn   = 1'b0;
    btn      = '0;
    cur_time = '0;
  end

  task automatic chk(input string name, input logic [16:0] got, input logic [16:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] model_time();
    return {m_mer[0], 4'(m_h), 6'(m_mi), 6'(m_s)};
  endfunction

  // driver: one clock of stimulus plus the model's prediction for that edge
  task automatic step(input logic [5:0] b, input logic rst, input logic [16:0] cur);
    snap_t sn;
    int d;
    @(negedge clk);
    #1;
    btn      = b;
    resetn   = ~rst;
    cur_time = cur;
    if (rst) begin
      m_md = 0; m_f = 0; m_h = 0; m_mi = 0; m_s = 0; m_mer = 0; m_since = 0;
    end else begin
      case (m_md)
        0: if ((b & K_MODE) != 0) begin
          m_h = int'(cur[15:12]); m_mi = int'(cur[11:6]); m_s = int'(cur[5:0]); m_mer = int'(cur[16]);
          if (m_h > 11) begin m_h = m_h - 12; m_mer = 1; end
          if (m_mi > 59) m_mi = 0;
          if (m_s > 59) m_s = 0;
          m_md = 1; m_f = 0; m_since = 0;
        end
        1: begin
          if (b != 0) m_since = 0; else m_since++;
          if ((b & K_CANCEL) != 0) m_md = 0;
          else if ((b & K_SAVE) != 0) begin m_md = 2; exp_q.push_back(model_time()); end
          else if ((b & K_NEXT) != 0) m_f = (m_f + 1) % 4;
          else if (((b & K_UP) != 0) != ((b & K_DOWN) != 0)) begin
            d = ((b & K_UP) != 0) ? 1 : -1;
            case (m_f)
              0: m_h  = (m_h + d + 12) % 12;
              1: m_mi = (m_mi + d + 60) % 60;
              2: m_s  = (m_s + d + 60) % 60;
              default: m_mer = 1 - m_mer;
            endcase
          end
          else if (b == 0 && m_since == TMO) m_md = 0;
        end
        default: m_md = 0;
      endcase
    end
    sn.t  = model_time();
    sn.sv = (m_md == 2);
    sn.ed = (m_md == 1);
    sn.fs = (m_md == 1) ? 2'(m_f) : 2'd0;
    sn.bl = (m_md == 1) && (((m_since / BH) % 2) == 0);
    sn.st = (m_md == 0) ? 3'(IDLE) : (m_md == 2) ? 3'(COMMIT) : 3'(int'(EDIT_HOUR) + m_f);
    stat_q.push_back(sn);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    snap_t s;
    if (stat_q.size() > 0) begin
      s = stat_q.pop_front();
      chk("in_time",   in_time,               s.t);
      chk("saved",     17'(is_saved_time),    17'(s.sv));
      chk("editing",   17'(editing),          17'(s.ed));
      chk("field_sel", 17'(field_sel),        17'(s.fs));
      chk("blink",     17'(blink),            17'(s.bl));
      chk("state",     17'(fsm_state),        17'(s.st));
      if (is_saved_time) begin
        if (exp_q.size() == 0) chk("unexpected_strobe", 17'd1, 17'd0);
        else chk("saved_time", in_time, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [5:0] b;
    step(0, 1, 17'h0);
    step(0, 1, 17'h0);

    // capture, step hour, commit
    step(K_MODE, 0, {1'b0, 4'd10, 6'd30, 6'd15});
    step(K_UP,   0, 17'h0);
    step(K_SAVE, 0, 17'h0);
    step(0, 0, 17'h0);
    step(0, 0, 17'h0);

    // wraps on every field
    step(K_MODE, 0, {1'b0, 4'd3, 6'd59, 6'd0});
    step(K_NEXT, 0, 17'h0);
    step(K_UP,   0, 17'h0);
    step(K_NEXT, 0, 17'h0);
    step(K_DOWN, 0, 17'h0);
    step(K_NEXT, 0, 17'h0);
    step(K_UP,   0, 17'h0);
    step(K_NEXT, 0, 17'h0);
    step(K_CANCEL, 0, 17'h0);
    step(K_MODE, 0, {1'b0, 4'd11, 6'd0, 6'd0});
    step(K_UP,   0, 17'h0);
    step(K_DOWN, 0, 17'h0);
    step(K_SAVE, 0, 17'h0);
    step(0, 0, 17'h0);

    // sanitize on capture
    step(K_MODE, 0, {1'b0, 4'd14, 6'd63, 6'd5});
    step(K_CANCEL, 0, 17'h0);
    step(K_UP, 0, 17'h0);

    // priority
    step(K_MODE, 0, {1'b1, 4'd5, 6'd20, 6'd40});
    step(K_SAVE | K_CANCEL, 0, 17'h0);
    step(0, 0, 17'h0);
    step(K_MODE, 0, {1'b0, 4'd7, 6'd1, 6'd2});
    step(K_UP | K_DOWN, 0, 17'h0);
    step(K_NEXT | K_UP, 0, 17'h0);
    step(K_MODE, 0, 17'h0);
    step(K_SAVE | K_NEXT, 0, 17'h0);
    step(0, 0, 17'h0);

    // timeout with blink running
    step(K_MODE, 0, {1'b0, 4'd1, 6'd2, 6'd3});
    for (int i = 0; i < TMO + 4; i++) step(0, 0, 17'h0);

    // reset during the strobe cycle
    step(K_MODE, 0, {1'b1, 4'd9, 6'd45, 6'd50});
    step(K_SAVE, 0, 17'h0);
    step(0, 1, 17'h0);
    step(0, 0, 17'h0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        for (int j = 0; j < TMO + 2; j++) step(0, 0, 17'($urandom));
      end else begin
        b = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
        if ($urandom_range(0, 2) == 0) b = 6'(1 << $urandom_range(0, 5));
        step(b, ($urandom_range(0, 199) == 0), 17'($urandom));
      end
    end

    step(0, 0, 17'h0);
    step(0, 0, 17'h0);
    @(negedge clk);
    @(negedge clk);
    chk("exp_q_drained", 17'(exp_q.size()), 17'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
